// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: valid/ready request
// in, single-cycle response out after a fixed number of wait states.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] INIT_VAL    = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  output logic [31:0] RspRData,
  output logic        RspErr,
  output logic        Busy
);

  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;

  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_hs;
  logic          w_enter_resp;
  logic          w_acc_write;
  logic          w_acc_err;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [AW-1:0] w_idx;

  assign w_hs = (r_state == S_IDLE) && ReqValid;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ReqValid) begin
          w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Wait-state counter: one count per WAIT cycle, cleared elsewhere
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Request capture on handshake
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_hs) begin
      r_write <= ReqWrite;
      r_addr  <= ReqAddr;
      r_wdata <= ReqWData;
    end
  end

  // With zero wait states RESP is entered on the handshake edge itself, so the
  // access must use the live request rather than the not-yet-latched copy.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_acc_write = ReqWrite;
      w_acc_addr  = ReqAddr;
      w_acc_wdata = ReqWData;
    end else begin
      w_acc_write = r_write;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
  end

  assign w_acc_err    = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr >= ADDR_LIMIT);
  assign w_idx        = w_acc_addr[AW+1:2];
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

  // Backing store: full clear on reset, commit only on a clean store
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= INIT_VAL;
      end
    end else if (w_enter_resp && w_acc_write && !w_acc_err) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

  // Response payload captured on the edge entering RESP
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_err   <= w_acc_err;
      r_rdata <= (w_acc_write || w_acc_err) ? '0 : r_mem[w_idx];
    end
  end

  // Outputs are decoded from state only and forced quiet while in reset
  always_comb begin
    ReqReady = !Rst && (r_state == S_IDLE);
    RspValid = !Rst && (r_state == S_RESP);
    Busy     = !Rst && (r_state != S_IDLE);
    RspRData = RspValid ? r_rdata : '0;
    RspErr   = RspValid && r_err;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (2 and 0 wait states)
// checked against an array-based memory model with cycle-accurate timing.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [2][DEPTH];
  int unsigned busy_from [2];
  int unsigned busy_to   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .INIT_VAL(32'h0000_0000)) u_dut_w2 (
    .Clk(clk), .Rst(rst[0]), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
    .ReqWrite(req_write[0]), .ReqAddr(req_addr[0]), .ReqWData(req_wdata[0]),
    .RspValid(rsp_valid[0]), .RspRData(rsp_rdata[0]), .RspErr(rsp_err[0]), .Busy(busy[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .INIT_VAL(32'h0000_0000)) u_dut_w0 (
    .Clk(clk), .Rst(rst[1]), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
    .ReqWrite(req_write[1]), .ReqAddr(req_addr[1]), .ReqWData(req_wdata[1]),
    .RspValid(rsp_valid[1]), .RspRData(rsp_rdata[1]), .RspErr(rsp_err[1]), .Busy(busy[1])
  );

  function automatic int unsigned wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: word array indexed by addr/4; errors never touch the array
  task automatic push_req(input int k, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
    exp_t        e;
    bit          err;
    int unsigned idx;
    err     = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    idx     = addr / 4;
    e.err   = err;
    e.rdata = 32'h0;
    if (!err) begin
      if (wr) model[k][idx] = wdata;
      else    e.rdata = model[k][idx];
    end
    e.cyc = cyc + wait_of(k) + 1;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    busy_from[k] = cyc + 1;
    busy_to[k]   = cyc + wait_of(k) + 1;
  endtask

  task automatic do_reset(input int k, input int n);
    rst[k]       = 1'b1;
    req_valid[k] = 1'b0;
    if (k == 0) q0.delete();
    else        q1.delete();
    busy_from[k] = 1;
    busy_to[k]   = 0;
    for (int i = 0; i < DEPTH; i++) model[k][i] = 32'h0000_0000;
    repeat (n) @(posedge clk);
    #1 rst[k] = 1'b0;
    @(negedge clk);
    chk($sformatf("dut%0d_post_reset_ready", k), req_ready[k], 1);
    chk($sformatf("dut%0d_post_reset_busy", k), busy[k], 0);
    chk($sformatf("dut%0d_post_reset_rspvalid", k), rsp_valid[k], 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_valid[k] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        push_req(k, wr, addr, wdata);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    n_fail++;
    $display("FAIL dut%0d_accept_timeout: got no ReqReady, expected acceptance within 40 cycles", k);
    req_valid[k] = 1'b0;
  endtask

  task automatic do_held(input int k, input int n);
    int acc;
    acc          = 0;
    req_write[k] = 1'b0;
    req_addr[k]  = 32'h0000_0004;
    req_wdata[k] = $urandom();
    req_valid[k] = 1'b1;
    for (int i = 0; i < n * int'(wait_of(k) + 2); i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        push_req(k, 1'b0, 32'h0000_0004, 32'h0);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    req_valid[k] = 1'b0;
    chk($sformatf("dut%0d_held_accepts", k), acc, n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input int k, input int n);
    logic [31:0] addr;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
        1:       addr = $urandom() | 32'h0000_0100;
        2:       addr = $urandom_range(0, 63) << 2;
        default: addr = $urandom_range(0, 15) << 2;
      endcase
      do_req(k, 1'($urandom_range(0, 1)), addr, $urandom());
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic monitor(input int k);
    exp_t        e;
    logic        exp_busy;
    int unsigned qs;
    if (rst[k]) begin
      chk($sformatf("dut%0d_reset_ready", k), req_ready[k], 0);
      chk($sformatf("dut%0d_reset_busy", k), busy[k], 0);
      chk($sformatf("dut%0d_reset_rspvalid", k), rsp_valid[k], 0);
      return;
    end
    exp_busy = (cyc >= busy_from[k]) && (cyc <= busy_to[k]);
    chk($sformatf("dut%0d_ready", k), req_ready[k], !exp_busy);
    chk($sformatf("dut%0d_busy", k), busy[k], exp_busy);
    qs = (k == 0) ? q0.size() : q1.size();
    if (rsp_valid[k]) begin
      if (qs == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut%0d_unexpected_rsp: got RspValid=1, expected 0 (cycle %0d)", k, cyc);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d_rsp_cycle", k), cyc, e.cyc);
        chk($sformatf("dut%0d_rdata", k), rsp_rdata[k], e.rdata);
        chk($sformatf("dut%0d_err", k), rsp_err[k], e.err);
      end
    end else if (qs > 0) begin
      e = (k == 0) ? q0[0] : q1[0];
      if (e.cyc <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut%0d_missing_rsp: got RspValid=0, expected 1 (cycle %0d)", k, cyc);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k]       = 1'b1;
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      busy_from[k] = 1;
      busy_to[k]   = 0;
    end

    // 2-wait-state instance
    do_reset(0, 2);
    do_req(0, 1'b0, 32'h0000_0000, 32'h0);
    do_req(0, 1'b1, 32'h0000_0028, 32'h0000_0007);
    do_req(0, 1'b0, 32'h0000_0028, 32'h0);
    do_req(0, 1'b1, 32'h0000_002C, 32'h0000_0007);
    do_req(0, 1'b0, 32'h0000_002C, 32'h0);
    do_req(0, 1'b0, 32'h0000_0029, 32'h0);
    do_req(0, 1'b1, 32'h0000_00FC, 32'hA5A5_0FFC);
    do_req(0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF);
    do_req(0, 1'b0, 32'h0000_00FC, 32'h0);
    do_held(0, 3);
    rand_ops(0, 60);
    do_req(0, 1'b1, 32'h0000_0010, 32'h1234_5678);
    do_reset(0, 2);
    do_req(0, 1'b0, 32'h0000_0010, 32'h0);

    // 0-wait-state instance
    do_reset(1, 2);
    do_req(1, 1'b1, 32'h0000_0028, 32'h0000_0007);
    do_req(1, 1'b0, 32'h0000_0028, 32'h0);
    do_req(1, 1'b0, 32'h0000_0029, 32'h0);
    do_req(1, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF);
    do_req(1, 1'b0, 32'h0000_00FC, 32'h0);
    do_held(1, 3);
    rand_ops(1, 40);

    idle(6);
    chk("dut0_drain", q0.size(), 0);
    chk("dut1_drain", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MIPS core's load/store port. It serves `lw`/`sw` requests from the datapath over a valid/ready handshake.
- Backing store is a word array with a programmable number of wait states, so the core's stall logic can be exercised.
- Sits between the core's MEM stage and on-chip data RAM. It is the reading/answering end of the interface the core initiates.

Parameters:
- DEPTH, 64, number of 32-bit words in the store; address index = Addr[log2(DEPTH)+1:2].
- WAIT_CYCLES, 2, extra cycles between request acceptance and response (0 allowed).
- INIT_VAL, 32'h0000_0000, value of every word after reset.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- ReqValid  in  1  core presents a request this cycle.
- ReqReady  out  1  responder accepts a request this cycle.
- ReqWrite  in  1  1 = store (sw), 0 = load (lw).
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data.
- RspValid  out  1  response valid, held one cycle.
- RspRData  out  32  load data; 0 for stores and errors.
- RspErr  out  1  response flags misaligned or out-of-range access.
- Busy  out  1  request accepted, response not yet issued.

Behaviour:
- Reset (synchronous, Rst=1 at the edge):
  - State goes to IDLE and the wait counter clears.
  - Outputs: ReqReady=0 during reset, RspValid=0, RspRData=0, RspErr=0, Busy=0.
  - All DEPTH words are set to INIT_VAL. Clearing may be a reset loop, but it must be complete before ReqReady is first asserted.
  - Rst mid-transaction discards the pending request. No write commits unless already committed; no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ReqReady=1.
  - Handshake occurs when ReqValid && ReqReady at an edge. On the handshake, latch ReqWrite, ReqAddr and ReqWData, and set Busy=1.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - ReqReady=0.
  - Counter counts WAIT_CYCLES edges, then the FSM goes to RESP.
  - ReqValid is ignored. The core must hold it or re-present it; the request is never double-accepted.
- RESP:
  - For exactly one cycle: RspValid=1, RspRData/RspErr valid, ReqReady=0.
  - Next edge returns to IDLE with Busy=0.
- Latency: the handshake edge is cycle 0, and RspValid is high in cycle WAIT_CYCLES+1. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Error rules:
  - An access is an error when ReqAddr[1:0]!=0, or when ReqAddr >= 4*DEPTH.
  - On error: the store is not written, RspRData=0, RspErr=1.
- Stores:
  - The word is written at the edge entering RESP.
  - RspRData=0 for stores.
- Loads:
  - RspRData = word at the latched index, sampled at the edge entering RESP.
  - A load that follows a store to the same address returns the new data.
- Address wrap: none. Out-of-range addresses error; there is no aliasing.
- Simultaneous events: a ReqValid rising in the same cycle the FSM enters IDLE is accepted on the next edge. ReqReady is combinational from state only, never from ReqValid.

Test Plan:
- Reset check: Rst=1 for 2 cycles, then 0 → RspValid=0, Busy=0, ReqReady=1 in the first cycle after release; a load from 0x00 returns INIT_VAL=0 with RspErr=0.
- Store/load pair matching the core's test program, WAIT_CYCLES=2:
  - Store 0x0000_0007 to 0x28 (40) → RspValid 3 cycles after the handshake, RspRData=0, RspErr=0.
  - Then load 0x28 → RspRData=0x0000_0007.
  - Then store 7 to 0x2C and load 0x2C → 0x0000_0007.
- Latency sweep: WAIT_CYCLES=0 → RspValid 1 cycle after the handshake and ReqReady back high on the following cycle. WAIT_CYCLES=2 → ReqReady low for exactly 3 cycles per request.
- Errors:
  - Load at 0x29 → RspErr=1, RspRData=0.
  - Store 0xFFFF_FFFF at 0x100 with DEPTH=64 → RspErr=1; a subsequent load of 0xFC returns its prior contents, unchanged.
- Held ReqValid during WAIT: hold ReqValid=1 continuously with fixed ReqAddr=0x04 → exactly one acceptance per WAIT_CYCLES+2 cycles, with no extra RspValid pulses.
- Reset mid-operation: handshake a store of 0x1234_5678 to 0x10, then assert Rst during WAIT → no RspValid; after reset, a load of 0x10 returns 0.
